// File: rtl/mem_reader_if.sv
// mem_reader bus bundle: run/length command, RAM read port and the output
// byte stream. The master modport is the reader itself; slave is whoever
// drives the command, owns the RAM and consumes the stream.
// Optional: MEM_READER_CHECKSUM_EN adds the csum signal.
interface mem_reader_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          run;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          abort;
  logic [AW-1:0] addr;
  logic          rden;
  logic [DW-1:0] q;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          done;
`ifdef MEM_READER_CHECKSUM_EN
  logic [DW-1:0] csum;
`endif

  modport master (
    input  run, start_addr, len, abort, q, dout_ready,
    output addr, rden, dout, dout_valid, busy, done
`ifdef MEM_READER_CHECKSUM_EN
    , output csum
`endif
  );

  modport slave (
    output run, start_addr, len, abort, q, dout_ready,
    input  addr, rden, dout, dout_valid, busy, done
`ifdef MEM_READER_CHECKSUM_EN
    , input csum
`endif
  );
endinterface

// File: rtl/mem_reader.sv
// mem_reader: walks RAM from start_addr for len bytes, one read at a time,
// and hands each byte out on a valid/ready stream. Used for dump/readback.
// RD_LAT is the RAM read latency (1..3 clocks from rden to valid q).
// Optional: MEM_READER_CHECKSUM_EN adds a running modulo-2^DW sum (csum)
// of the bytes accepted in the current transfer.
module mem_reader #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_reader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FIN
  } state_t;

  // Index of the WAIT cycle on which q is valid and gets captured.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW:0]   rem_q, rem_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dval_q, dval_d;
  logic          hs;
`ifdef MEM_READER_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  // Byte leaves the block on this edge.
  assign hs = dval_q & bus.dout_ready;

  // Next-state logic: sequencing of request, latency wait and output hold.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    dout_d  = dout_q;
    dval_d  = dval_q;
`ifdef MEM_READER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
`ifdef MEM_READER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (bus.len != '0) begin
            cur_d   = bus.start_addr;
            rem_d   = bus.len;
            state_d = S_REQ;
          end else begin
            // Empty transfer: report completion without touching RAM.
            state_d = S_FIN;
          end
        end
      end
      S_REQ: begin
        wcnt_d = '0;
        if (bus.abort) state_d = S_FIN;
        else           state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.abort) begin
          // The read in flight is simply never captured.
          state_d = S_FIN;
        end else if (wcnt_q == WAIT_LAST) begin
          dout_d  = bus.q;
          dval_d  = 1'b1;
          state_d = S_HOLD;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_HOLD: begin
        if (hs) begin
          dval_d = 1'b0;
          rem_d  = rem_q - 1'b1;
`ifdef MEM_READER_CHECKSUM_EN
          csum_d = csum_q + dout_q;
`endif
          // A byte accepted together with abort still counts.
          if (rem_q == (AW+1)'(1) || bus.abort) begin
            state_d = S_FIN;
          end else begin
            cur_d   = cur_q + 1'b1;  // wraps modulo 2^AW
            state_d = S_REQ;
          end
        end else if (bus.abort) begin
          dval_d  = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        dval_d  = 1'b0;
      end
    endcase
  end

  // State register; reset drops any transfer at once, with no done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
`ifdef MEM_READER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
`ifdef MEM_READER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.addr       = cur_q;
  assign bus.rden       = (state_q == S_REQ);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dval_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_FIN);
`ifdef MEM_READER_CHECKSUM_EN
  assign bus.csum       = csum_q;
`endif

endmodule

// File: tb/tb_mem_reader.sv
// Testbench for mem_reader: table of transfers checked against a RAM model
// and an expected-byte queue, plus stall, abort and mid-transfer reset.
// Build with MEM_READER_CHECKSUM_EN defined to also check csum.
module tb_mem_reader;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_reader_if #(.AW(8), .DW(8)) bus ();

  mem_reader #(.AW(8), .DW(8), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model with RD_LAT-deep read pipeline.
  logic [7:0] ram [256];
  logic [7:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (bus.rden) rd_pipe[0] <= ram[bus.addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.q = rd_pipe[RD_LAT-1];

  // Monitor: counts read strobes and done pulses, records accepted bytes.
  int         cyc;
  int         rden_cnt;
  int         done_cnt;
  logic [7:0] last_rden_addr;
  logic [7:0] act_q [$];
  int         hs_cyc [$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.rden) begin
      rden_cnt       <= rden_cnt + 1;
      last_rden_addr <= bus.addr;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.dout_valid && bus.dout_ready) begin
      act_q.push_back(bus.dout);
      hs_cyc.push_back(cyc);
    end
  end

  int         tests;
  int         fails;
  logic [7:0] exp_q [$];
  int         rd_idx;
  logic [7:0] exp_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue run; expected bytes come from the RAM model.
  task automatic do_run(input logic [7:0] sa, input logic [8:0] n, input int n_exp);
    logic [7:0] a;
    exp_sum = 8'h00;
    for (int i = 0; i < n_exp; i++) begin
      a = sa + 8'(i);
      exp_q.push_back(ram[a]);
      exp_sum = exp_sum + ram[a];
    end
    bus.start_addr = sa;
    bus.len        = n;
    bus.run        = 1'b1;
    step();
    bus.run        = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (!bus.done && k < budget) begin
      step();
      k++;
    end
    check(name, {31'd0, bus.done}, 32'd1);
    step();
    check({name, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic compare_bytes(input string name);
    check({name, "_count"}, act_q.size() - rd_idx, exp_q.size());
    while (exp_q.size() > 0 && rd_idx < act_q.size()) begin
      check(name, act_q[rd_idx], exp_q.pop_front());
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = act_q.size();
  endtask

  typedef struct {
    logic [7:0] sa;
    logic [8:0] len;
    logic [7:0] last_addr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int base_r, base_d, k, gap_bad, first;
    logic [7:0] held;

    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    ram[8'h10] = 8'h11; ram[8'h11] = 8'h22; ram[8'h12] = 8'h33; ram[8'h13] = 8'h44;
    ram[8'h40] = 8'hF0; ram[8'h41] = 8'h20; ram[8'h42] = 8'h05;

    vecs[0] = '{8'h10, 9'd4,   8'h13};
    vecs[1] = '{8'h20, 9'd0,   8'h00};
    vecs[2] = '{8'hFE, 9'd3,   8'h00};
    vecs[3] = '{8'h40, 9'd3,   8'h42};
    vecs[4] = '{8'h80, 9'd1,   8'h80};
    vecs[5] = '{8'h00, 9'd256, 8'hFF};

    bus.run = 1'b0; bus.start_addr = '0; bus.len = '0;
    bus.abort = 1'b0; bus.dout_ready = 1'b1;
    rd_idx = 0;

    // Reset state.
    step(); step();
    check("rst_addr",  {24'd0, bus.addr}, 32'd0);
    check("rst_rden",  {31'd0, bus.rden}, 32'd0);
    check("rst_dout",  {24'd0, bus.dout}, 32'd0);
    check("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
`ifdef MEM_READER_CHECKSUM_EN
    check("rst_csum",  {24'd0, bus.csum}, 32'd0);
`endif
    rst = 1'b1;
    step();

    // Table of straight transfers with dout_ready held high.
    for (int v = 0; v < 6; v++) begin
      base_r = rden_cnt;
      base_d = done_cnt;
      first  = act_q.size();
      do_run(vecs[v].sa, vecs[v].len, int'(vecs[v].len));
`ifdef MEM_READER_CHECKSUM_EN
      check("csum_clear", {24'd0, bus.csum}, 32'd0);
`endif
      if (vecs[v].len != 0) begin
        k = 1;
        while (!bus.dout_valid && k < 20) begin
          step();
          k++;
        end
        check("first_valid_latency", k, 2 + RD_LAT);
      end else begin
        check("len0_done_next", {31'd0, bus.done}, 32'd1);
      end
      wait_done(int'(vecs[v].len) * (RD_LAT + 2) + 20, "done");
      gap_bad = 0;
      for (int i = first + 1; i < act_q.size(); i++)
        if (hs_cyc[i] - hs_cyc[i-1] != RD_LAT + 2) gap_bad++;
      check("throughput_gaps", gap_bad, 0);
      check("rden_count", rden_cnt - base_r, int'(vecs[v].len));
      check("done_count", done_cnt - base_d, 1);
      if (vecs[v].len != 0)
        check("last_addr", {24'd0, last_rden_addr}, {24'd0, vecs[v].last_addr});
`ifdef MEM_READER_CHECKSUM_EN
      check("csum", {24'd0, bus.csum}, {24'd0, exp_sum});
      if (vecs[v].sa == 8'h40) check("csum_F0_20_05", {24'd0, bus.csum}, 32'h15);
`endif
      $display("[TB] vec %0d: start=0x%02h len=%0d bytes=%0d", v, vecs[v].sa, vecs[v].len,
               act_q.size() - rd_idx);
      compare_bytes("byte");
    end

    // Stall: hold ready low for 5 clocks while a byte is presented.
    bus.dout_ready = 1'b0;
    base_r = rden_cnt;
    base_d = done_cnt;
    do_run(8'h10, 9'd4, 4);
    k = 0;
    while (!bus.dout_valid && k < 20) begin
      step();
      k++;
    end
    held = ram[8'h10];
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'd0, bus.dout_valid}, 32'd1);
      check("stall_dout",  {24'd0, bus.dout}, {24'd0, held});
    end
    check("stall_no_rden", rden_cnt - base_r, 1);
    bus.dout_ready = 1'b1;
    wait_done(40, "stall_done");
    check("stall_rden_total", rden_cnt - base_r, 4);
    check("stall_done_count", done_cnt - base_d, 1);
    $display("[TB] stall: start=0x10 len=4 bytes=%0d", act_q.size() - rd_idx);
    compare_bytes("stall_byte");

    // Abort during WAIT of the second byte.
    base_r = rden_cnt;
    base_d = done_cnt;
    do_run(8'h10, 9'd4, 1);
    k = 0;
    while (!(bus.rden && rden_cnt - base_r == 1) && k < 20) begin
      step();
      k++;
    end
    check("abort_second_req", {31'd0, bus.rden}, 32'd1);
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_fin", {31'd0, bus.done}, 32'd1);
    check("abort_no_valid", {31'd0, bus.dout_valid}, 32'd0);
    step();
    check("abort_idle", {31'd0, bus.busy}, 32'd0);
    step();
    check("abort_done_count", done_cnt - base_d, 1);
    check("abort_rden_count", rden_cnt - base_r, 2);
    $display("[TB] abort: start=0x10 len=4 bytes=%0d", act_q.size() - rd_idx);
    compare_bytes("abort_byte");

    // Reset in the middle of HOLD.
    bus.dout_ready = 1'b0;
    base_d = done_cnt;
    do_run(8'h10, 9'd4, 0);
    k = 0;
    while (!bus.dout_valid && k < 20) begin
      step();
      k++;
    end
    check("prereset_valid", {31'd0, bus.dout_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_addr",  {24'd0, bus.addr}, 32'd0);
    check("midrst_rden",  {31'd0, bus.rden}, 32'd0);
    check("midrst_dout",  {24'd0, bus.dout}, 32'd0);
    check("midrst_valid", {31'd0, bus.dout_valid}, 32'd0);
    check("midrst_busy",  {31'd0, bus.busy}, 32'd0);
    check("midrst_done",  {31'd0, bus.done}, 32'd0);
    step(); step();
    rst = 1'b1;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("midrst_no_done", done_cnt - base_d, 0);
    check("midrst_idle", {31'd0, bus.busy}, 32'd0);
    $display("[TB] reset mid-HOLD: bytes=%0d", act_q.size() - rd_idx);
    compare_bytes("midrst_byte");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
